ahb_slave_mem: RTL and testbench
================================

# ahb_slave_mem

AHB-Lite memory responder: the slave end of the bus driven by `AHB_Master`. It decodes address-phase controls, inserts a programmable number of wait states, and performs byte, halfword or word writes and word reads against an internal word array. It reports misaligned or oversized transfers with the two-cycle AHB ERROR response. It sits behind one `HSEL` line of the master's slave-select decode.

## Interface
- `ADDR_W`, 8: word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_STATES`, 1: HREADYOUT-low cycles inserted per OKAY transfer, legal range 0..15.

- `HCLK` in 1: bus clock, rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HWRITE` in 1: 1 = write, 0 = read.
- `HSIZE` in 3: 000 byte, 001 half, 010 word; anything larger is an error.
- `HBURST` in 3: accepted, ignored; every beat is decoded independently.
- `HPROT` in 4: accepted, ignored.
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HREADY` in 1: bus-level ready; qualifies the address phase.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADYOUT` out 1: this slave's ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `HRDATA` out 32: read data.

## Operation
- **Address-phase accept:** on a rising `HCLK` with `HSEL & HREADY & HTRANS[1]`, the block registers `HADDR`, `HWRITE` and `HSIZE`.
- **IDLE/BUSY:** `HTRANS` = IDLE or BUSY gives a zero-wait OKAY with no array access.
- **Error check** (on the accepted address): any of the following flags an error.
  - `HSIZE` > 010.
  - Half access with `HADDR[0]` = 1.
  - Word access with `HADDR[1:0]` ≠ 0.
- **Word index:** `HADDR[ADDR_W+1:2]`. Upper address bits are ignored, so the array aliases.
- **States:**
  - IDLE: `HREADYOUT`=1, `HRESP`=0.
  - WAIT: `HREADYOUT`=0, `HRESP`=0. Counts down from WAIT_STATES.
  - DONE: `HREADYOUT`=1, `HRESP`=0. Final data-phase cycle.
  - ERR1: `HREADYOUT`=0, `HRESP`=1.
  - ERR2: `HREADYOUT`=1, `HRESP`=1.
- **Transitions** on accept:
  - Error → ERR1 → ERR2.
  - OKAY with WAIT_STATES=0 → DONE.
  - OKAY with WAIT_STATES>0 → WAIT.
  - WAIT with counter = 1 → DONE.
- **Leaving DONE/ERR2:** go to the state for a new accept in the same cycle (back-to-back pipelining); otherwise go to IDLE.
- **ERR1:** always proceeds to ERR2, even if the master cancels with IDLE.
- **Writes:** committed on the rising edge that ends DONE, using `HWDATA`. Byte lanes are little-endian and selected by the registered `HSIZE` and `HADDR[1:0]`. Unselected bytes are unchanged.
- **Reads:** `HRDATA` is the full word `mem[idx]` during DONE of a read; 0 in every other state.
- **Error transfers:** never modify the array.

## Timing
- **Reset values:** `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, state IDLE, wait counter 0.
  - Reset asserted mid-transfer aborts the transfer immediately and any pending write is dropped.
  - The array is not reset.
- **OKAY latency:** WAIT_STATES+1 cycles from accept to completion.
- **ERROR latency:** always 2 cycles, independent of WAIT_STATES.
- **Read-after-write:** a read accepted in the DONE cycle of a write to the same word returns the new data. The write commits at the same edge that starts the read's data phase, and `HRDATA` is combinational from the array.
- **During WAIT/ERR1:** `HREADY` is low bus-wide, so no new accept can occur.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS codes: IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE codes: BYTE/HALF/WORD.
  - HRESP codes: OKAY/ERROR.
  - The state enum: IDLE/WAIT/DONE/ERR1/ERR2.
- Sub-module `ahb_slave_ram`: 2^ADDR_W × 32 array with a 4-bit byte-enable synchronous write and an asynchronous read. The FSM, counter and lane decode stay in `ahb_slave_mem`.

## Test plan
- **Word write/read, WAIT_STATES=1:** NONSEQ word write of 345 to 0x0000_0010, then a word read of the same address.
  - Each transfer shows one `HREADYOUT`-low cycle.
  - The read returns `HRDATA`=0x0000_0159 with `HRESP`=0.
- **Byte-lane write:** word write 0x1122_3344 to 0x20, then a byte write of 0xAA in lane 2 at address 0x22, then a word read of 0x20.
  - The read returns 0x11AA_3344.
- **Misaligned word:** word write of 567 to 0xABCD_EF12.
  - Response is ERR1 (`HREADYOUT`=0, `HRESP`=1) then ERR2 (`HREADYOUT`=1, `HRESP`=1).
  - A follow-up word read at 0xABCD_EF10 returns the prior contents, i.e. the array is unchanged.
- **Back-to-back, WAIT_STATES=0:** write 10 to 0x40, then read 0x40 accepted in the write's DONE cycle.
  - Both complete with `HREADYOUT` never low.
  - The read returns 10.
- **HSIZE/IDLE/BUSY:** an access with `HSIZE`=011 → ERROR response.
  - `HTRANS`=IDLE, or BUSY with `HSEL`=1 → `HREADYOUT`=1, `HRESP`=0, no array change.
- **Reset mid-WAIT:** set WAIT_STATES=3, start a write of 0xDEAD_BEEF to 0x80, and pull `HRESETn` low in the second wait cycle.
  - Outputs go to reset values immediately.
  - A word read of 0x80 after reset returns the pre-write contents.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and slave FSM state type.
// Used by the ahb_slave_mem memory responder and its RAM.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // Oversized or misaligned transfers get the ERROR response.
   function automatic logic addr_err(input logic [2:0] size,
                                     input logic [1:0] a);
      logic e;
      e = 1'b0;
      case (size)
         HSIZE_BYTE: e = 1'b0;
         HSIZE_HALF: e = a[0];
         HSIZE_WORD: e = |a;
         default:    e = 1'b1;
      endcase
      return e;
   endfunction

   // Little-endian byte lanes touched by a transfer.
   function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                            input logic [1:0] a);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << a;
         HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word array with byte-enable synchronous write, async read.
// Ports: clk, we, be[3:0], idx, wdata in; rdata out.
module ahb_slave_ram
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [2**ADDR_W];

   // Contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: wait states, byte/half/word writes, ERROR resp.
// Ports: AHB slave signals (HCLK, HRESETn, HSEL, HADDR..HWDATA in;
// HREADYOUT, HRESP, HRDATA out).
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [2:0]        size_q, size_d;

   logic        accept;
   logic        take;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_rdata;
   logic        unused_ok;

   // Burst/protection are ignored; upper address bits alias.
   assign unused_ok = ^{HBURST, HPROT, HTRANS[0],
                        HADDR[31:ADDR_W+2]};

   assign accept = HSEL & HREADY & HTRANS[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      take    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            state_d = ST_IDLE;
            take    = accept;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = ST_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      // Completion cycles overlap the next address phase.
      if (take) begin
         addr_d  = HADDR[ADDR_W+1:0];
         write_d = HWRITE;
         size_d  = HSIZE;
         if (addr_err(HSIZE, HADDR[1:0])) begin
            state_d = ST_ERR1;
         end else if (WS == 4'd0) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state_q)
         ST_WAIT: HREADYOUT = 1'b0;
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
   end

   // Write lands on the edge closing DONE; reset kills it via state_q.
   assign ram_we = (state_q == ST_DONE) & write_q;
   assign ram_be = lane_mask(size_q, addr_q[1:0]);

   assign HRDATA = (state_q == ST_DONE && !write_q) ? ram_rdata : '0;

   ahb_slave_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk   (HCLK),
      .we    (ram_we),
      .be    (ram_be),
      .idx   (addr_q[ADDR_W+1:2]),
      .wdata (HWDATA),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three slaves (WAIT_STATES 1, 0, 3) on one bus.
// Directed scenarios plus random traffic against an array model.
module tb_ahb_slave_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel_on;
   logic [1:0]  cur;
   logic [2:0]  hsel;
   logic [31:0] haddr, hwdata;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hready;
   logic [2:0]  hro, hresp;
   logic [31:0] hrd [3];

   logic [31:0] mdl [3][256];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign hsel   = sel_on ? (3'b001 << cur) : 3'b000;
   assign hready = hro[cur];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ahb_slave_mem #(
         .ADDR_W(8),
         .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
      ) u_dut (
         .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[g]),
         .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
         .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
         .HREADY(hready), .HWDATA(hwdata),
         .HREADYOUT(hro[g]), .HRESP(hresp[g]), .HRDATA(hrd[g])
      );
   end

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   function automatic bit bad(input logic [2:0] sz, input logic [31:0] a);
      return (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
   endfunction

   function automatic void mwrite(input int k, input logic [31:0] a,
                                  input logic [2:0] sz,
                                  input logic [31:0] wd);
      int idx, off;
      idx = int'((a >> 2) & 32'hFF);
      off = int'(a % 4);
      for (int b = off; b < off + (1 << sz); b++)
         mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
   endfunction

   function automatic logic [31:0] mread(input int k, input logic [31:0] a);
      return mdl[k][int'((a >> 2) & 32'hFF)];
   endfunction

   // One non-pipelined transfer on slave cur.
   task automatic xfer(input bit wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] rd, output int waits,
                       output logic lowresp, output logic finresp,
                       output bit tmo);
      @(posedge clk); #1;
      sel_on = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = wr;
      hsize  = sz;
      hburst = 3'($urandom);
      hprot  = 4'($urandom);
      @(posedge clk); #1;
      htrans = 2'b00;
      hwdata = wd;
      haddr  = $urandom;
      waits = 0; lowresp = 1'b0; finresp = 1'bx; rd = 'x; tmo = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (hro[cur]) begin
            rd = hrd[cur];
            finresp = hresp[cur];
            tmo = 1'b0;
            break;
         end
         waits++;
         lowresp = lowresp | hresp[cur];
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sel_on = 1'b0; cur = 2'd0; htrans = 2'b00;
      haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = '0;
      hprot = '0; hwdata = '0;
      #3;
      checks++;
      if (hro !== 3'b111) $display("FAIL reset_hreadyout got %b want 111", hro);
      else passed++;
      checks++;
      if (hresp !== 3'b000) $display("FAIL reset_hresp got %b want 000", hresp);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (hrd[k] !== 32'h0) $display("FAIL reset_hrdata%0d got %h want 0", k, hrd[k]);
         else passed++;
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_word_rw;
      logic [31:0] rd; int w; logic lr, fr; bit t;
      cur = 2'd0;
      xfer(1'b1, 32'h10, 3'd2, 32'd345, rd, w, lr, fr, t);
      mwrite(0, 32'h10, 3'd2, 32'd345);
      checks++;
      if (t || w !== 1 || fr !== 1'b0)
         $display("FAIL word_wr_timing got waits=%0d resp=%b tmo=%0d want 1/0/0", w, fr, t);
      else passed++;
      xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, lr, fr, t);
      checks++;
      if (t || w !== 1 || fr !== 1'b0)
         $display("FAIL word_rd_timing got waits=%0d resp=%b tmo=%0d want 1/0/0", w, fr, t);
      else passed++;
      checks++;
      if (rd !== 32'h0000_0159) $display("FAIL word_rd_data got %h want 00000159", rd);
      else passed++;
   endtask

   task automatic test_byte_lane;
      logic [31:0] rd; int w; logic lr, fr; bit t;
      cur = 2'd0;
      xfer(1'b1, 32'h20, 3'd2, 32'h1122_3344, rd, w, lr, fr, t);
      mwrite(0, 32'h20, 3'd2, 32'h1122_3344);
      xfer(1'b1, 32'h22, 3'd0, 32'h00AA_0000, rd, w, lr, fr, t);
      mwrite(0, 32'h22, 3'd0, 32'h00AA_0000);
      checks++;
      if (t || w !== 1 || fr !== 1'b0)
         $display("FAIL byte_wr_timing got waits=%0d resp=%b want 1/0", w, fr);
      else passed++;
      xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, w, lr, fr, t);
      checks++;
      if (rd !== 32'h11AA_3344) $display("FAIL byte_lane_data got %h want 11aa3344", rd);
      else passed++;
   endtask

   task automatic test_misaligned;
      logic [31:0] rd; int w; logic lr, fr; bit t;
      cur = 2'd0;
      xfer(1'b1, 32'hABCD_EF10, 3'd2, 32'h5A5A_0001, rd, w, lr, fr, t);
      mwrite(0, 32'hABCD_EF10, 3'd2, 32'h5A5A_0001);
      xfer(1'b1, 32'hABCD_EF12, 3'd2, 32'd567, rd, w, lr, fr, t);
      checks++;
      if (t || w !== 1 || lr !== 1'b1 || fr !== 1'b1)
         $display("FAIL misaligned_resp got waits=%0d err1=%b err2=%b want 1/1/1", w, lr, fr);
      else passed++;
      xfer(1'b0, 32'hABCD_EF10, 3'd2, 32'h0, rd, w, lr, fr, t);
      checks++;
      if (rd !== 32'h5A5A_0001) $display("FAIL misaligned_nochange got %h want 5a5a0001", rd);
      else passed++;
   endtask

   task automatic test_back_to_back;
      logic low; logic [31:0] rd; bit ok1;
      cur = 2'd1; low = 1'b0;
      @(posedge clk); #1;
      sel_on = 1'b1; htrans = 2'b10; haddr = 32'h40;
      hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      hwdata = 32'd10; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b0;
      @(negedge clk);
      low = low | ~hro[1];
      ok1 = (hrd[1] === 32'h0);
      @(posedge clk); #1;
      htrans = 2'b00;
      @(negedge clk);
      low = low | ~hro[1];
      rd = hrd[1];
      @(posedge clk); #1;
      mwrite(1, 32'h40, 3'd2, 32'd10);
      checks++;
      if (low !== 1'b0 || !ok1)
         $display("FAIL b2b_ready got low=%b wr_hrdata_zero=%0d want 0/1", low, ok1);
      else passed++;
      checks++;
      if (rd !== 32'd10) $display("FAIL b2b_read got %h want 0000000a", rd);
      else passed++;
   endtask

   task automatic test_hsize_idle_busy;
      logic [31:0] rd; int w; logic lr, fr; bit t;
      for (int k = 1; k < 3; k++) begin
         cur = 2'(k);
         xfer(1'b0, 32'h44, 3'd3, 32'h0, rd, w, lr, fr, t);
         checks++;
         if (t || w !== 1 || lr !== 1'b1 || fr !== 1'b1 || rd !== 32'h0)
            $display("FAIL hsize3_err%0d got waits=%0d err1=%b err2=%b rd=%h want 1/1/1/0", k, w, lr, fr, rd);
         else passed++;
      end
      cur = 2'd1;
      xfer(1'b1, 32'h44, 3'd2, 32'h77, rd, w, lr, fr, t);
      mwrite(1, 32'h44, 3'd2, 32'h77);
      for (int m = 0; m < 2; m++) begin
         @(posedge clk); #1;
         sel_on = 1'b1; htrans = 2'(m); haddr = 32'h44;
         hwrite = 1'b1; hsize = 3'd2;
         @(posedge clk); #1;
         hwdata = 32'hFFFF_FFFF;
         @(negedge clk);
         checks++;
         if (hro[1] !== 1'b1 || hresp[1] !== 1'b0)
            $display("FAIL idle_busy%0d got ready=%b resp=%b want 1/0", m, hro[1], hresp[1]);
         else passed++;
         @(posedge clk); #1;
         htrans = 2'b00;
      end
      xfer(1'b0, 32'h44, 3'd2, 32'h0, rd, w, lr, fr, t);
      checks++;
      if (rd !== mread(1, 32'h44)) $display("FAIL idle_busy_nochange got %h want %h", rd, mread(1, 32'h44));
      else passed++;
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] rd; int w; logic lr, fr; bit t; logic w1, w2;
      cur = 2'd2;
      xfer(1'b1, 32'h80, 3'd2, 32'h1234_5678, rd, w, lr, fr, t);
      mwrite(2, 32'h80, 3'd2, 32'h1234_5678);
      checks++;
      if (t || w !== 3) $display("FAIL ws3_waits got %0d want 3", w);
      else passed++;
      @(posedge clk); #1;
      sel_on = 1'b1; htrans = 2'b10; haddr = 32'h80;
      hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
      @(negedge clk); w1 = hro[2];
      @(posedge clk);
      @(negedge clk); w2 = hro[2];
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (w1 !== 1'b0 || w2 !== 1'b0) $display("FAIL mid_wait_low got %b%b want 00", w1, w2);
      else passed++;
      checks++;
      if (hro[2] !== 1'b1 || hresp[2] !== 1'b0 || hrd[2] !== 32'h0)
         $display("FAIL mid_wait_reset got ready=%b resp=%b rd=%h want 1/0/0", hro[2], hresp[2], hrd[2]);
      else passed++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(1'b0, 32'h80, 3'd2, 32'h0, rd, w, lr, fr, t);
      checks++;
      if (rd !== 32'h1234_5678) $display("FAIL mid_wait_dropped got %h want 12345678", rd);
      else passed++;
   endtask

   task automatic test_random;
      logic [31:0] rd, a, wd, exp_rd; int w, r, exp_w; logic lr, fr;
      bit t, wr, e; logic [2:0] sz;
      for (int k = 0; k < 3; k++) begin
         cur = 2'(k);
         for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a = 32'(i * 4) | ($urandom & 32'hFFFF_FC00);
            xfer(1'b1, a, 3'd2, wd, rd, w, lr, fr, t);
            mwrite(k, a, 3'd2, wd);
         end
         for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2
                 : 3'($urandom_range(3, 7));
            a  = $urandom & 32'hFFFF_FC3F;
            wr = 1'($urandom);
            wd = $urandom;
            e  = bad(sz, a);
            exp_w  = e ? 1 : ws_of(k);
            exp_rd = (e || wr) ? 32'h0 : mread(k, a);
            xfer(wr, a, sz, wd, rd, w, lr, fr, t);
            if (!e && wr) mwrite(k, a, sz, wd);
            checks++;
            if (t || w !== exp_w || lr !== e || fr !== e || rd !== exp_rd)
               $display("FAIL rand%0d_%0d a=%h sz=%0d wr=%0d got w=%0d lr=%b fr=%b rd=%h want w=%0d resp=%0d rd=%h",
                        k, n, a, sz, wr, w, lr, fr, rd, exp_w, e, exp_rd);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_lane();
      test_misaligned();
      test_back_to_back();
      test_hsize_idle_busy();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
